fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Write-side arbiter that shares the asynchronous FIFO's single write port among NREQ producers in the write clock domain. It drives the write pointer block's enable from a round-robin, burst-limited grant and throttles on the registered full flag. It presents one selected data word to the FIFO memory each cycle and returns a per-requester accept strobe. A saturating stall counter reports how many cycles an owner was held off by full.

## Interface
- NREQ, 4: number of producers; 2..8.
- DATA_WIDTH, 8: FIFO word width.
- BURST_MAX, 4: maximum accepted beats per grant; 1..16.
- wclk  input  1  write clock; the block's only clock.
- w_rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-producer write request; the producer holds the word valid while req is high.
- wdata_in  input  NREQ*DATA_WIDTH  producer words; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- full  input  1  registered FIFO full flag from the write pointer block.
- w_en  output  1  FIFO write enable (combinational).
- wdata  output  DATA_WIDTH  selected word to FIFO memory (combinational).
- gnt  output  NREQ  one-hot registered grant; all zero when idle.
- ack  output  NREQ  one-hot accept strobe; the word is consumed on this edge.
- busy  output  1  high while in BURST.
- stall_cnt  output  16  saturating count of full-stalled cycles.

## Operation
- Two-state FSM.
  - IDLE: gnt=0, busy=0.
  - BURST: exactly one gnt bit set (the owner), busy=1.
- Round-robin pointer `last` records the most recent owner. Reset value is NREQ-1, so requester 0 wins first.
- Selection: the first requester with req high, scanning from last+1 upward modulo NREQ.
- IDLE -> BURST: any req high. The selected requester becomes owner next edge, and beat_cnt is cleared to 0.
- In BURST:
  - w_en = req[owner] & ~full.
  - ack[owner] = w_en.
  - wdata = wdata_in slice of owner.
  - When w_en=0, wdata is still driven with the owner's slice. Bench must not check it.
- beat_cnt increments on each accepted beat. Width is clog2(BURST_MAX)+1.
- BURST exits when either:
  - an accepted beat occurs with beat_cnt == BURST_MAX-1, or
  - req[owner] is low. No write happens in that cycle.
- On exit:
  - `last` is set to the owner.
  - If any req is high in the exit cycle, the next owner is selected from the updated pointer and BURST re-enters with beat_cnt=0. There is no idle bubble.
  - Otherwise the FSM goes to IDLE.
- Re-selection can choose the same owner again only if no other requester has req high.
- full while in BURST:
  - w_en=0 and beat_cnt holds.
  - gnt stays with the owner; full never causes an exit.
  - stall_cnt increments when req[owner] & full, saturating at 16'hFFFF.
- The block does not block writes on its own: it relies on full as registered by the write pointer block. The pointer block additionally gates its increment with ~full.

## Timing
- Reset (w_rst high at an edge): the next state is:
  - FSM = IDLE, gnt=0, ack=0, w_en=0, busy=0.
  - beat_cnt=0, last=NREQ-1, stall_cnt=0.
- Reset mid-burst aborts the burst with no partial-beat ack. The FIFO pointers are reset independently in their own domain.
- Grant latency: req rising in IDLE at edge k gives gnt at edge k+1. The first w_en can occur in the cycle after edge k+1.
- Handover latency: 0 cycles. The last beat of owner A and gnt to owner B are separated by one edge.
- w_en, ack and wdata are combinational from req, full and the registered state. Their paths go directly to the write pointer and memory, so no output register is added.
- A full rise is seen one cycle late by design. The pointer's own ~full gating covers the overlap.
- Exit in the same cycle as a new req arriving: the new req is eligible for the handover selection.

## Test plan
- Single producer: req[2]=1 for 10 words, BURST_MAX=4, full=0.
  - Expect gnt=4'b0100 from cycle 1.
  - Bursts of 4, 4, 2 with re-grant to 2 and no bubble; 10 acks total.
  - FSM to IDLE after req drops.
- Fairness: all four req held high, full=0.
  - Owners in order 0,1,2,3,0, each exactly 4 consecutive w_en.
  - Never two bursts to the same owner back to back.
- Full stall: owner 1 mid-burst at beat 2, full=1 for 5 cycles.
  - w_en=0 and gnt holds 4'b0010; stall_cnt=5.
  - Beats 3 and 4 complete after full drops, then handover.
- Early release: owner 0 drops req after 1 beat while req[3]=1.
  - Next edge gnt=4'b1000 and last=0; no write in the drop cycle.
- Reset mid-burst: w_rst pulsed at beat 2 of owner 2.
  - Next edge all outputs 0 and stall_cnt=0.
  - With all req high, the first post-reset owner is 0.
- Saturation: full=1 with req[0]=1 for 70000 cycles.
  - stall_cnt stops at 16'hFFFF; w_en stays 0 throughout.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO: round-robin, burst-limited sharing of the
// single write port among NREQ producers, throttled by the registered full flag.
module fifo_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                       wclk,
  input  logic                       w_rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata_in,
  input  logic                       full,
  output logic                       w_en,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            ack,
  output logic                       busy,
  output logic [15:0]                stall_cnt
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BCW  = $clog2(BURST_MAX) + 1;
  localparam logic [BCW-1:0]  LAST_BEAT = BCW'(BURST_MAX - 1);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREQ - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state, w_stateNext;
  logic [IDXW-1:0] r_owner, w_ownerNext;
  logic [IDXW-1:0] r_last, w_lastNext;
  logic [IDXW-1:0] w_sel;
  logic [NREQ-1:0] r_gnt, w_gntNext;
  logic [BCW-1:0]  r_beatCnt, w_beatCntNext;
  logic [15:0]     r_stallCnt;
  logic            w_ownerReq;
  logic            w_anyReq;
  logic            w_accept;
  logic            w_exit;

  // First requester strictly after base, wrapping; base itself is checked last.
  function automatic logic [IDXW-1:0] pickNext(input logic [NREQ-1:0] r,
                                               input logic [IDXW-1:0] base);
    logic [IDXW-1:0] res;
    logic [IDXW-1:0] idx;
    res = base;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDXW'((int'(base) + i) % NREQ);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    w_ownerReq = req[r_owner];
    w_anyReq   = |req;
    w_accept   = (r_state == S_BURST) & w_ownerReq & ~full;
    w_exit     = (r_state == S_BURST) &
                 (~w_ownerReq | (w_accept & (r_beatCnt == LAST_BEAT)));
    // On handover the pointer has already moved to the exiting owner.
    w_sel      = pickNext(req, (r_state == S_BURST) ? r_owner : r_last);
  end

  always_comb begin
    w_stateNext   = r_state;
    w_ownerNext   = r_owner;
    w_lastNext    = r_last;
    w_gntNext     = r_gnt;
    w_beatCntNext = r_beatCnt;
    case (r_state)
      S_IDLE: begin
        if (w_anyReq) begin
          w_stateNext   = S_BURST;
          w_ownerNext   = w_sel;
          w_gntNext     = NREQ'(1) << w_sel;
          w_beatCntNext = '0;
        end
      end
      S_BURST: begin
        if (w_exit) begin
          w_lastNext    = r_owner;
          w_beatCntNext = '0;
          if (w_anyReq) begin
            w_ownerNext = w_sel;
            w_gntNext   = NREQ'(1) << w_sel;
          end else begin
            w_stateNext = S_IDLE;
            w_gntNext   = '0;
          end
        end else if (w_accept) begin
          w_beatCntNext = r_beatCnt + BCW'(1);
        end
      end
      default: begin
        w_stateNext = S_IDLE;
        w_gntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (w_rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_last     <= LAST_IDX;
      r_gnt      <= '0;
      r_beatCnt  <= '0;
      r_stallCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_owner   <= w_ownerNext;
      r_last    <= w_lastNext;
      r_gnt     <= w_gntNext;
      r_beatCnt <= w_beatCntNext;
      if ((r_state == S_BURST) && w_ownerReq && full && (r_stallCnt != 16'hFFFF))
        r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  always_comb begin
    w_en      = w_accept;
    ack       = w_accept ? r_gnt : '0;
    wdata     = wdata_in[r_owner*DATA_WIDTH +: DATA_WIDTH];
    gnt       = r_gnt;
    busy      = (r_state == S_BURST);
    stall_cnt = r_stallCnt;
  end

endmodule
